// File: rtl/ntt_rej_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_rej_sampler_if
//  Purpose  : Stream bundle between the SHAKE-128 squeeze port, the
//             rejection sampler and the coefficient consumer.
//             Byte stream  : byte_data / byte_valid / byte_ready
//             Coeff stream : coeff_data / coeff_idx / coeff_valid /
//                            coeff_last / coeff_ready
//  Modports : master - the sampler (sinks bytes, sources coefficients)
//             slave  - the surrounding sponge / consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface ntt_rej_sampler_if #(
    parameter int IW = 8
) ();
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [11:0]   coeff_data;
    logic [IW-1:0] coeff_idx;
    logic          coeff_valid;
    logic          coeff_last;
    logic          coeff_ready;

    modport master (
        input  byte_data, byte_valid, coeff_ready,
        output byte_ready, coeff_data, coeff_idx, coeff_valid, coeff_last
    );

    modport slave (
        output byte_data, byte_valid, coeff_ready,
        input  byte_ready, coeff_data, coeff_idx, coeff_valid, coeff_last
    );
endinterface
`default_nettype wire

// File: rtl/ntt_rej_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_rej_sampler
//  Purpose  : ML-KEM SampleNTT rejection sampler. Takes the SHAKE-128
//             squeeze byte stream, splits each 3-byte group into two 12-bit
//             candidates and forwards those below Q as indexed polynomial
//             coefficients until N_COEFFS have been delivered.
//  Ports    : clk, rst_n (async, active-low)
//             start  - pulse: clear count, begin a new polynomial (any state)
//             bus    - ntt_rej_sampler_if.master (byte in, coeff out streams)
//             busy   - sampling in progress
//             done   - last coefficient delivered, held until next start
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_rej_sampler #(
    parameter int N_COEFFS = 256,
    parameter int Q        = 3329,
    parameter int IW       = $clog2(N_COEFFS)
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               start,
    ntt_rej_sampler_if.master bus,
    output logic              busy,
    output logic              done
);

    // count must be able to hold N_COEFFS itself, hence the +1
    localparam int              CW     = $clog2(N_COEFFS + 1);
    localparam logic [12:0]     c_Q    = 13'(Q);
    localparam logic [CW-1:0]   c_LAST = CW'(N_COEFFS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GET0 = 3'd1,
        ST_GET1 = 3'd2,
        ST_GET2 = 3'd3,
        ST_OUT1 = 3'd4,
        ST_OUT2 = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t        r_state;
    logic [7:0]    r_b0;
    logic [7:0]    r_b1;
    logic [11:0]   r_d1;
    logic [11:0]   r_d2;
    logic [CW-1:0] r_count;

    logic          w_d1_ok;
    logic          w_d2_ok;
    logic          w_offer;
    logic [11:0]   w_cand;

    // Q may be 4096, so the compare is done one bit wider than the candidate
    assign w_d1_ok = ({1'b0, r_d1} < c_Q);
    assign w_d2_ok = ({1'b0, r_d2} < c_Q);

    // Every output below is a decode of registered state only; neither
    // byte_valid nor coeff_ready reaches an output combinationally.
    assign w_offer = ((r_state == ST_OUT1) && w_d1_ok) ||
                     ((r_state == ST_OUT2) && w_d2_ok);
    assign w_cand  = (r_state == ST_OUT2) ? r_d2 : r_d1;

    assign bus.byte_ready  = (r_state == ST_GET0) || (r_state == ST_GET1) ||
                             (r_state == ST_GET2);
    assign bus.coeff_valid = w_offer;
    assign bus.coeff_data  = w_offer ? w_cand : 12'd0;
    assign bus.coeff_idx   = w_offer ? r_count[IW-1:0] : '0;
    assign bus.coeff_last  = w_offer && (r_count == c_LAST);
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done            = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_b0    <= 8'd0;
            r_b1    <= 8'd0;
            r_d1    <= 12'd0;
            r_d2    <= 12'd0;
            r_count <= '0;
        end else if (start) begin
            // Abort wins over everything, including a coefficient handshake
            // happening this same cycle: that coefficient is not counted.
            r_state <= ST_GET0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_GET0: begin
                    if (bus.byte_valid) begin
                        r_b0    <= bus.byte_data;
                        r_state <= ST_GET1;
                    end
                end
                ST_GET1: begin
                    if (bus.byte_valid) begin
                        r_b1    <= bus.byte_data;
                        r_state <= ST_GET2;
                    end
                end
                ST_GET2: begin
                    if (bus.byte_valid) begin
                        r_d1    <= {r_b1[3:0], r_b0};
                        r_d2    <= {bus.byte_data, r_b1[7:4]};
                        r_state <= ST_OUT1;
                    end
                end
                ST_OUT1: begin
                    if (!w_d1_ok) begin
                        // rejected candidate: one bubble cycle, no valid
                        r_state <= ST_OUT2;
                    end else if (bus.coeff_ready) begin
                        r_count <= r_count + CW'(1);
                        // finishing on d1 drops d2 rather than carrying it
                        r_state <= (r_count == c_LAST) ? ST_DONE : ST_OUT2;
                    end
                end
                ST_OUT2: begin
                    if (!w_d2_ok) begin
                        r_state <= ST_GET0;
                    end else if (bus.coeff_ready) begin
                        r_count <= r_count + CW'(1);
                        r_state <= (r_count == c_LAST) ? ST_DONE : ST_GET0;
                    end
                end
                default: begin
                    // IDLE and DONE wait for start
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_rej_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_rej_sampler
//  Purpose  : Self-checking bench for ntt_rej_sampler. Single-group vectors
//             from a table, abort/reset sequences, and full polynomials
//             checked against a reference SampleNTT model, with and without
//             random byte_valid / coeff_ready stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_rej_sampler;

    localparam int N        = 256;
    localparam int c_QV     = 3329;
    localparam int c_LIMIT  = 6000;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    int n_checks = 0;
    int n_fail   = 0;

    ntt_rej_sampler_if #(.IW(8)) bif ();

    ntt_rej_sampler #(
        .N_COEFFS (N),
        .Q        (c_QV),
        .IW       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bif),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic        ok1;
        logic [11:0] d1;
        logic        ok2;
        logic [11:0] d2;
    } vec_t;

    vec_t        vecs[8];
    logic [7:0]  stream[$];
    logic [11:0] exp_q[$];
    int          exp_bytes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference SampleNTT over the current stream
    task automatic build_expected();
        logic [7:0]  b0, b1, b2;
        logic [11:0] d1, d2;
        exp_q.delete();
        exp_bytes = 0;
        for (int g = 0; (3 * g + 2 < stream.size()) && (exp_q.size() < N); g++) begin
            b0 = stream[3*g];
            b1 = stream[3*g+1];
            b2 = stream[3*g+2];
            d1 = {b1[3:0], b0};
            d2 = {b2, b1[7:4]};
            exp_bytes += 3;
            if (int'(d1) < c_QV) exp_q.push_back(d1);
            if ((exp_q.size() < N) && (int'(d2) < c_QV)) exp_q.push_back(d2);
        end
    endtask

    task automatic feed_byte(input logic [7:0] b);
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        @(negedge clk);
        bif.byte_valid = 1'b0;
    endtask

    // One start + one 3-byte group, cycle-exact checks of OUT1/OUT2/GET0
    task automatic apply_vec(input vec_t v, input int k);
        start = 1'b1; bif.byte_valid = 1'b0; bif.coeff_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_get0_ready", k), bif.byte_ready, 1);
        chk($sformatf("v%0d_busy", k), busy, 1);
        feed_byte(v.b0);
        feed_byte(v.b1);
        feed_byte(v.b2);
        chk($sformatf("v%0d_out1_valid", k), bif.coeff_valid, v.ok1);
        chk($sformatf("v%0d_out1_byte_ready", k), bif.byte_ready, 0);
        if (v.ok1) begin
            chk($sformatf("v%0d_out1_data", k), bif.coeff_data, v.d1);
            chk($sformatf("v%0d_out1_idx", k), bif.coeff_idx, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_out2_valid", k), bif.coeff_valid, v.ok2);
        if (v.ok2) begin
            chk($sformatf("v%0d_out2_data", k), bif.coeff_data, v.d2);
            chk($sformatf("v%0d_out2_idx", k), bif.coeff_idx, v.ok1 ? 1 : 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_regroup_ready", k), bif.byte_ready, 1);
        chk($sformatf("v%0d_regroup_valid", k), bif.coeff_valid, 0);
    endtask

    // Full polynomial from the global stream, optional random stalls
    task automatic run_stream(input string tag, input bit stalls);
        int          got;
        int          consumed;
        int          cycles;
        int          cyc_last;
        logic        pv;
        logic [11:0] pd;
        logic [7:0]  pi;
        build_expected();
        got = 0; consumed = 0; cycles = 0; cyc_last = -10; pv = 1'b0;
        pd = '0; pi = '0;
        start = 1'b1; bif.byte_valid = 1'b0; bif.coeff_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!done && cycles < c_LIMIT) begin
            if (pv) begin
                chk({tag, "_hold_valid"}, bif.coeff_valid, 1);
                chk({tag, "_hold_data"}, bif.coeff_data, pd);
                chk({tag, "_hold_idx"}, bif.coeff_idx, pi);
            end
            pv = 1'b0;
            bif.coeff_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bif.coeff_valid) begin
                if (got < exp_q.size()) begin
                    chk({tag, "_coeff_data"}, bif.coeff_data, exp_q[got]);
                    chk({tag, "_coeff_idx"}, bif.coeff_idx, got);
                    chk({tag, "_coeff_last"}, bif.coeff_last, (got == N - 1));
                end else begin
                    chk({tag, "_extra_coeff"}, bif.coeff_idx, 32'hFFFF_FFFF);
                end
                if (bif.coeff_ready) begin
                    got++;
                    cyc_last = cycles;
                end else begin
                    pv = 1'b1; pd = bif.coeff_data; pi = bif.coeff_idx;
                end
            end
            if (consumed < stream.size()) begin
                bif.byte_valid = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
                bif.byte_data  = stream[consumed];
                if (bif.byte_ready && bif.byte_valid) consumed++;
            end else begin
                bif.byte_valid = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bif.byte_valid = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_coeff_count"}, got, N);
        chk({tag, "_done_timing"}, cycles, cyc_last + 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_byte_ready_low"}, bif.byte_ready, 0);
        chk({tag, "_bytes_consumed"}, consumed, exp_bytes);
        // a stalled byte offered after done must not be taken
        bif.byte_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_still_done"}, done, 1);
        chk({tag, "_no_valid_after_done"}, bif.coeff_valid, 0);
        bif.byte_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] x;
        vecs[0] = '{8'h01, 8'h02, 8'h03, 1'b1, 12'd513,  1'b1, 12'd48};
        vecs[1] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 12'd0,    1'b1, 12'd15};
        vecs[2] = '{8'h00, 8'h0D, 8'h00, 1'b1, 12'd3328, 1'b1, 12'd0};
        vecs[3] = '{8'h01, 8'h0D, 8'h00, 1'b0, 12'd0,    1'b1, 12'd0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 12'd0,    1'b0, 12'd0};
        vecs[5] = '{8'h34, 8'h12, 8'hAB, 1'b1, 12'd564,  1'b1, 12'd2737};
        vecs[6] = '{8'h00, 8'hE0, 8'hD0, 1'b1, 12'd0,    1'b0, 12'd0};
        vecs[7] = '{8'h00, 8'hF0, 8'hCF, 1'b1, 12'd0,    1'b1, 12'd3327};

        rst_n = 1'b0; start = 1'b0;
        bif.byte_valid = 1'b0; bif.byte_data = 8'h00; bif.coeff_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_byte_ready", bif.byte_ready, 0);
        chk("rst_coeff_valid", bif.coeff_valid, 0);
        chk("rst_coeff_last", bif.coeff_last, 0);
        chk("rst_coeff_data", bif.coeff_data, 0);
        chk("rst_coeff_idx", bif.coeff_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        bif.byte_valid = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", bif.byte_ready, 0);
        bif.byte_valid = 1'b0;

        for (int k = 0; k < 8; k++) apply_vec(vecs[k], k);

        // start during GET1 with a byte offered: byte dropped, back to GET0
        start = 1'b1; @(negedge clk); start = 1'b0;
        feed_byte(8'hFF);
        start = 1'b1; bif.byte_valid = 1'b1; bif.byte_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; bif.byte_valid = 1'b0;
        chk("abort_get1_ready", bif.byte_ready, 1);
        bif.coeff_ready = 1'b1;
        feed_byte(8'h01); feed_byte(8'h02); feed_byte(8'h03);
        chk("abort_get1_data", bif.coeff_data, 513);
        chk("abort_get1_idx", bif.coeff_idx, 0);

        // start in OUT1 while a coefficient is offered and coeff_ready high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_out1_valid", bif.coeff_valid, 0);
        chk("abort_out1_ready", bif.byte_ready, 1);
        feed_byte(8'h01); feed_byte(8'h02); feed_byte(8'h03);
        chk("abort_out1_data", bif.coeff_data, 513);
        chk("abort_out1_idx", bif.coeff_idx, 0);
        @(negedge clk);
        chk("abort_out1_d2_idx", bif.coeff_idx, 1);

        // Crafted polynomial: 4095 reject, then 128 all-accept groups, so the
        // 256th coefficient comes from d1 and d2 = 0 must be discarded.
        stream.delete();
        stream.push_back(8'hFF); stream.push_back(8'hFF); stream.push_back(8'h00);
        for (int k = 1; k <= 128; k++) begin
            stream.push_back(8'(k));
            stream.push_back(8'h05);
            stream.push_back(8'(k & 127));
        end
        for (int k = 0; k < 6; k++) stream.push_back(8'h11);
        run_stream("craft", 1'b0);
        apply_vec(vecs[0], 100);

        // Pseudo-random byte stream, without then with stalls
        stream.delete();
        x = 32'h1234_5678;
        for (int k = 0; k < 900; k++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
            stream.push_back(x[7:0]);
        end
        run_stream("rand", 1'b0);
        run_stream("stall", 1'b1);

        // asynchronous reset while OUT2 is offering a coefficient
        start = 1'b1; bif.coeff_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_byte(8'h01); feed_byte(8'h02); feed_byte(8'h03);
        @(negedge clk);
        chk("out2_pre_rst_valid", bif.coeff_valid, 1);
        chk("out2_pre_rst_data", bif.coeff_data, 48);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bif.coeff_valid, 0);
        chk("async_rst_data", bif.coeff_data, 0);
        chk("async_rst_idx", bif.coeff_idx, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_byte_ready", bif.byte_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bif.byte_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_ready", bif.byte_ready, 0);
        chk("post_rst_idle_done", done, 0);
        bif.byte_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
